// File: rtl/water_pump_ctrl.sv
// water_pump_ctrl: sequencing layer between the water_level sensor and the pump
// driver. Debounces the 4-bit level reading, fills with hysteresis between
// LOW_TH and HIGH_TH, enforces a cooldown between fills, and latches faults for
// dry-run timeout and out-of-range sensor codes.
module water_pump_ctrl #(
    parameter int LOW_TH     = 4,
    parameter int HIGH_TH    = 11,
    parameter int STABLE_CYC = 4,
    parameter int MAX_RUN    = 255,
    parameter int COOL_CYC   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr_fault,
    input  logic [3:0] wl,
    output logic       sensor_en,
    output logic       pump_on,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [2:0] state
);

    localparam logic [3:0]  LOW_Q     = 4'(LOW_TH);
    localparam logic [3:0]  HIGH_Q    = 4'(HIGH_TH);
    localparam logic [3:0]  STABLE_Q  = 4'(STABLE_CYC);
    localparam logic [3:0]  ERR_MIN   = 4'd14;
    localparam logic [15:0] RUN_LAST  = 16'(MAX_RUN - 1);
    localparam logic [15:0] COOL_LAST = 16'(COOL_CYC - 1);

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_RANGE   = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MONITOR  = 3'd1,
        S_FILL     = 3'd2,
        S_COOLDOWN = 3'd3,
        S_FAULT    = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_fault_code;
    logic [1:0]  w_next_code;
    logic [3:0]  r_wl_q;
    logic [3:0]  r_cnt;
    logic [15:0] r_run_cnt;
    logic [15:0] r_cool_cnt;
    logic        w_stable;
    logic        w_sensor_err;

    assign w_stable     = (r_cnt >= STABLE_Q);
    assign w_sensor_err = w_stable && (r_wl_q >= ERR_MIN);

    // State and latched fault code registers; fault code only moves with FAULT entry/exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_fault_code <= CODE_NONE;
        end else begin
            r_state      <= w_next_state;
            r_fault_code <= w_next_code;
        end
    end

    // Next-state logic; branch order inside each state encodes transition priority.
    always_comb begin
        w_next_state = r_state;
        w_next_code  = r_fault_code;
        case (r_state)
            S_IDLE: begin
                if (en) w_next_state = S_MONITOR;
            end
            S_MONITOR: begin
                if (!en) begin
                    w_next_state = S_IDLE;
                end else if (w_sensor_err) begin
                    w_next_state = S_FAULT;
                    w_next_code  = CODE_RANGE;
                end else if (w_stable && (r_wl_q <= LOW_Q)) begin
                    w_next_state = S_FILL;
                end
            end
            S_FILL: begin
                if (!en) begin
                    w_next_state = S_IDLE;
                end else if (w_sensor_err) begin
                    w_next_state = S_FAULT;
                    w_next_code  = CODE_RANGE;
                end else if (w_stable && (r_wl_q >= HIGH_Q)) begin
                    // Reaching the high mark on the timeout cycle is a normal stop.
                    w_next_state = S_COOLDOWN;
                end else if (r_run_cnt == RUN_LAST) begin
                    w_next_state = S_FAULT;
                    w_next_code  = CODE_TIMEOUT;
                end
            end
            S_COOLDOWN: begin
                if (!en) begin
                    w_next_state = S_IDLE;
                end else if (r_cool_cnt == COOL_LAST) begin
                    w_next_state = S_MONITOR;
                end
            end
            S_FAULT: begin
                if (clr_fault) begin
                    w_next_state = S_IDLE;
                    w_next_code  = CODE_NONE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_code  = CODE_NONE;
            end
        endcase
    end

    // Debounce filter: counts consecutive identical samples, held clear while idle.
    always_ff @(posedge clk) begin
        if (rst || (r_state == S_IDLE)) begin
            r_wl_q <= 4'd0;
            r_cnt  <= 4'd0;
        end else begin
            r_wl_q <= wl;
            if ((r_cnt == 4'd0) || (wl == r_wl_q)) begin
                if (r_cnt < STABLE_Q) r_cnt <= r_cnt + 4'd1;
            end else begin
                r_cnt <= 4'd1;
            end
        end
    end

    // Pump run-time counter: zero outside FILL so every fill starts from 0.
    always_ff @(posedge clk) begin
        if (rst || (r_state != S_FILL)) begin
            r_run_cnt <= 16'd0;
        end else begin
            r_run_cnt <= r_run_cnt + 16'd1;
        end
    end

    // Cooldown counter: zero outside COOLDOWN so every cooldown starts from 0.
    always_ff @(posedge clk) begin
        if (rst || (r_state != S_COOLDOWN)) begin
            r_cool_cnt <= 16'd0;
        end else begin
            r_cool_cnt <= r_cool_cnt + 16'd1;
        end
    end

    assign state      = r_state;
    assign sensor_en  = (r_state == S_MONITOR) || (r_state == S_FILL) || (r_state == S_COOLDOWN);
    assign pump_on    = (r_state == S_FILL);
    assign fault      = (r_state == S_FAULT);
    assign fault_code = r_fault_code;

endmodule
